// File: rtl/calc_siruri_pkg.sv
// ----------------------------------------------------------------------------
// calc_siruri_pkg
// Shared constants for the sequence calculator: element and counter widths,
// and the state encoding of the pair feeder.
// ----------------------------------------------------------------------------
package calc_siruri_pkg;

  localparam int DATA_W = 8;  // element width, fixed by the compute stage
  localparam int CNT_W  = 8;  // element counter / seq_len width

  // Feeder states: no element held / previous element held.
  localparam logic [0:0] S_FIRST = 1'b0;
  localparam logic [0:0] S_PAIR  = 1'b1;

endpackage : calc_siruri_pkg

// File: rtl/compute_stage.sv
// ----------------------------------------------------------------------------
// compute_stage
// Combinational compute stage fed by seq_pair_feeder:
//   result = 2*in1 + in0 + (in0 even ? 3 : -1), wrapped mod 256.
// Ports:
//   in0    in  8  earlier element x[i]
//   in1    in  8  later element x[i+1]
//   result out 8  computed value
// ----------------------------------------------------------------------------
module compute_stage (
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  output logic [7:0] result
);

  // -1 mod 256 is 8'hFF, so the odd case is a plain 8-bit add as well.
  assign result = {in1[6:0], 1'b0} + in0 + (in0[0] ? 8'hFF : 8'h03);

endmodule : compute_stage

// File: rtl/seq_pair_feeder.sv
// ----------------------------------------------------------------------------
// seq_pair_feeder
// Accepts a last-tagged byte stream and emits registered sliding pairs
// (x[i], x[i+1]) for the compute stage. A one-element sequence emits
// (x[0], 0). Also reports the element count of each sequence on its last
// pair and a sticky flag for sequences longer than 2^CNT_W-1 elements.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_data    in   DATA_W  sequence element
//   in_valid   in   1       in_data valid
//   in_last    in   1       in_data ends the current sequence
//   in_ready   out  1       element accepted when in_valid && in_ready
//   pair_in0   out  DATA_W  earlier element x[i]
//   pair_in1   out  DATA_W  later element x[i+1]
//   pair_valid out  1       pair valid
//   pair_last  out  1       pair is last of its sequence
//   pair_ready in   1       pair consumed when pair_valid && pair_ready
//   seq_len    out  CNT_W   element count, meaningful with pair_valid && pair_last
//   len_ovf    out  1       sticky: some sequence exceeded 2^CNT_W-1 elements
// ----------------------------------------------------------------------------
module seq_pair_feeder
  import calc_siruri_pkg::*;
#(
  parameter int DATA_W = calc_siruri_pkg::DATA_W,
  parameter int CNT_W  = calc_siruri_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] pair_in0,
  output logic [DATA_W-1:0] pair_in1,
  output logic              pair_valid,
  output logic              pair_last,
  input  logic              pair_ready,
  output logic [CNT_W-1:0]  seq_len,
  output logic              len_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]        state, state_nx;
  logic [DATA_W-1:0] prev;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              cnt_sat;
  logic              accept;
  logic              load;

  // Single output slot: an element can enter whenever the slot is empty or
  // is being drained this cycle. Independent of in_valid.
  assign in_ready = !pair_valid || pair_ready;

  // --------------------------------------------------------------------------
  // Next-state / accept logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    accept   = in_valid && in_ready;
    cnt_sat  = (cnt == CNT_MAX);
    cnt_inc  = cnt_sat ? CNT_MAX : cnt + CNT_W'(1);
    // A pair is produced by every accept in S_PAIR, and by a lone last
    // element in S_FIRST.
    load     = accept && ((state == S_PAIR) || in_last);
    state_nx = state;
    if (accept) begin
      state_nx = in_last ? S_FIRST : S_PAIR;
    end
  end

  // --------------------------------------------------------------------------
  // State, previous element, element counter, overflow flag
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FIRST;
      prev    <= '0;
      cnt     <= '0;
      len_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (state == S_FIRST) begin
          cnt <= CNT_W'(1);
          if (!in_last) begin
            prev <= in_data;
          end
        end else begin
          prev <= in_data;
          cnt  <= in_last ? '0 : cnt_inc;
          // An accept with the counter already at max would exceed it.
          if (cnt_sat) begin
            len_ovf <= 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output pair registers: load when free or being consumed, else hold
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_in0   <= '0;
      pair_in1   <= '0;
      pair_valid <= 1'b0;
      pair_last  <= 1'b0;
      seq_len    <= '0;
    end else if (load) begin
      // load implies accept, which implies the slot is free or draining.
      pair_in0   <= (state == S_PAIR) ? prev : in_data;
      pair_in1   <= (state == S_PAIR) ? in_data : '0;
      pair_valid <= 1'b1;
      pair_last  <= in_last;
      if (in_last) begin
        seq_len <= (state == S_PAIR) ? cnt_inc : CNT_W'(1);
      end
    end else if (pair_ready) begin
      pair_valid <= 1'b0;
    end
  end

endmodule : seq_pair_feeder

// File: tb/tb_seq_pair_feeder.sv
// ----------------------------------------------------------------------------
// tb_seq_pair_feeder
// Drives whole sequences into seq_pair_feeder (+ compute_stage), predicts the
// pair list of each sequence directly from its element list, and compares
// every consumed pair, its seq_len/len_ovf and the compute result on each
// consuming cycle. Also checks that a stalled pair stays put.
// ----------------------------------------------------------------------------
module tb_seq_pair_feeder;
  import calc_siruri_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [7:0]       pair_in0;
  logic [7:0]       pair_in1;
  logic             pair_valid;
  logic             pair_last;
  logic             pair_ready;
  logic [CNT_W-1:0] seq_len;
  logic             len_ovf;
  logic [7:0]       result;

  always #5 clk = ~clk;

  seq_pair_feeder u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .pair_in0   (pair_in0),
    .pair_in1   (pair_in1),
    .pair_valid (pair_valid),
    .pair_last  (pair_last),
    .pair_ready (pair_ready),
    .seq_len    (seq_len),
    .len_ovf    (len_ovf)
  );

  compute_stage u_compute (
    .in0    (pair_in0),
    .in1    (pair_in1),
    .result (result)
  );

  typedef struct {
    logic [7:0] in0;
    logic [7:0] in1;
    logic       last;
    logic [7:0] len;
    logic       ovf;
    logic [7:0] res;
  } pair_t;

  pair_t exp_q[$];
  pair_t obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit ovf_model = 1'b0;
  bit rand_mode = 1'b0;
  bit ready_en  = 1'b1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compute stage rule in plain integer arithmetic.
  function automatic logic [7:0] ref_result(input logic [7:0] a,
                                            input logic [7:0] b);
    int r;
    r = 2 * int'(b) + int'(a) + ((a % 2 == 0) ? 3 : -1);
    return 8'(r % 256);
  endfunction

  // Expected pair list of a whole sequence.
  task automatic model_seq(input logic [7:0] s[$], input bit with_last);
    int    n;
    pair_t p;
    n = s.size();
    if (n >= 256) ovf_model = 1'b1;
    if (n == 1 && with_last) begin
      p = '{in0: s[0], in1: 8'd0, last: 1'b1, len: 8'd1, ovf: ovf_model,
            res: ref_result(s[0], 8'd0)};
      exp_q.push_back(p);
    end
    for (int i = 0; i + 1 < n; i++) begin
      p.in0  = s[i];
      p.in1  = s[i+1];
      p.last = with_last && (i + 2 == n);
      p.len  = (n > 255) ? 8'd255 : 8'(n);
      p.ovf  = ovf_model;
      p.res  = ref_result(s[i], s[i+1]);
      exp_q.push_back(p);
    end
  endtask

  // Called aligned to posedge+1; returns aligned to posedge+1.
  task automatic send_seq(input logic [7:0] s[$], input bit with_last);
    int t;
    bit acc;
    model_seq(s, with_last);
    for (int i = 0; i < s.size(); i++) begin
      if (rand_mode) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_data  = s[i];
      in_last  = with_last && (i == s.size() - 1);
      in_valid = 1'b1;
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        t++;
        if (!acc && t > 300) begin
          check("accept_timeout", 32'd0, 32'd1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    ovf_model = 1'b0;
  endtask

  // Consumer: ready pattern applied just after each edge.
  always begin
    @(posedge clk);
    #1;
    pair_ready = ready_en && (!rand_mode || ($urandom_range(0, 3) != 0));
  end

  // Compare process: one pass per cycle, away from the active edge.
  bit    hold_pending = 1'b0;
  pair_t held;
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_in0", 32'(pair_in0), 32'(held.in0));
        check("hold_in1", 32'(pair_in1), 32'(held.in1));
        check("hold_valid", 32'(pair_valid), 32'd1);
        hold_pending = 1'b0;
      end
      if (!pair_valid) begin
        check("ready_when_empty", 32'(in_ready), 32'd1);
      end else if (!pair_ready) begin
        check("ready_when_stalled", 32'(in_ready), 32'd0);
        held.in0 = pair_in0;
        held.in1 = pair_in1;
        hold_pending = 1'b1;
      end else if (exp_q.size() == 0) begin
        check("unexpected_pair", 32'd1, 32'd0);
      end else begin
        pair_t e;
        pair_t o;
        e = exp_q.pop_front();
        check("pair_in0", 32'(pair_in0), 32'(e.in0));
        check("pair_in1", 32'(pair_in1), 32'(e.in1));
        check("pair_last", 32'(pair_last), 32'(e.last));
        check("result", 32'(result), 32'(e.res));
        if (e.last) begin
          check("seq_len", 32'(seq_len), 32'(e.len));
          check("len_ovf", 32'(len_ovf), 32'(e.ovf));
        end
        o = '{in0: pair_in0, in1: pair_in1, last: pair_last, len: seq_len,
              ovf: len_ovf, res: result};
        obs_q.push_back(o);
      end
    end
  end

  initial begin
    logic [7:0] q[$];
    int         t;

    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    pair_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_pair_valid", 32'(pair_valid), 32'd0);
    check("rst_seq_len", 32'(seq_len), 32'd0);
    check("rst_len_ovf", 32'(len_ovf), 32'd0);
    check("rst_pair_in0", 32'(pair_in0), 32'd0);
    @(posedge clk);
    #1;

    // 5,7,2(last)
    obs_q.delete();
    q = '{8'd5, 8'd7, 8'd2};
    send_seq(q, 1'b1);
    drain();
    check("t1_npairs", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("t1_res0", 32'(obs_q[0].res), 32'd18);
      check("t1_last0", 32'(obs_q[0].last), 32'd0);
      check("t1_res1", 32'(obs_q[1].res), 32'd10);
      check("t1_len", 32'(obs_q[1].len), 32'd3);
    end

    // 4(last)
    obs_q.delete();
    q = '{8'd4};
    send_seq(q, 1'b1);
    drain();
    check("t2_npairs", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) begin
      check("t2_in1", 32'(obs_q[0].in1), 32'd0);
      check("t2_res", 32'(obs_q[0].res), 32'd7);
      check("t2_len", 32'(obs_q[0].len), 32'd1);
    end

    // 1,2,3 with the first pair stalled for three cycles
    obs_q.delete();
    ready_en = 1'b0;
    q = '{8'd1, 8'd2, 8'd3};
    fork
      send_seq(q, 1'b1);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!pair_valid && t < 50);
        repeat (3) begin
          check("t3_stall_in_ready", 32'(in_ready), 32'd0);
          check("t3_stall_in0", 32'(pair_in0), 32'd1);
          check("t3_stall_in1", 32'(pair_in1), 32'd2);
          @(negedge clk);
        end
        ready_en = 1'b1;
      end
    join
    drain();
    check("t3_npairs", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("t3_res0", 32'(obs_q[0].res), 32'd4);
      check("t3_res1", 32'(obs_q[1].res), 32'd11);
      check("t3_last1", 32'(obs_q[1].last), 32'd1);
    end

    // 255,255(last): compute wrap
    obs_q.delete();
    q = '{8'd255, 8'd255};
    send_seq(q, 1'b1);
    drain();
    check("t4_npairs", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) check("t4_res", 32'(obs_q[0].res), 32'd252);

    // 9,8 with pair pending, reset, then 6,1(last)
    ready_en = 1'b0;
    q = '{8'd9, 8'd8};
    send_seq(q, 1'b0);
    @(negedge clk);
    check("t5_pending", 32'(pair_valid), 32'd1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("t5_rst_valid", 32'(pair_valid), 32'd0);
    check("t5_rst_seq_len", 32'(seq_len), 32'd0);
    check("t5_rst_last", 32'(pair_last), 32'd0);
    @(posedge clk);
    #1;
    ready_en = 1'b1;
    obs_q.delete();
    q = '{8'd6, 8'd1};
    send_seq(q, 1'b1);
    drain();
    check("t5_npairs", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) begin
      check("t5_in0", 32'(obs_q[0].in0), 32'd6);
      check("t5_len", 32'(obs_q[0].len), 32'd2);
      check("t5_res", 32'(obs_q[0].res), 32'd11);
    end

    // 257 random elements: counter saturation and sticky overflow
    rand_mode = 1'b1;
    obs_q.delete();
    q.delete();
    for (int i = 0; i < 257; i++) q.push_back(8'($urandom));
    send_seq(q, 1'b1);
    drain();
    check("t6_npairs", 32'(obs_q.size()), 32'd256);
    if (obs_q.size() == 256) begin
      check("t6_len", 32'(obs_q[255].len), 32'd255);
      check("t6_ovf", 32'(obs_q[255].ovf), 32'd1);
    end
    obs_q.delete();
    q = '{8'd3, 8'd4, 8'd5};
    send_seq(q, 1'b1);
    drain();
    check("t6_ovf_sticky", 32'(len_ovf), 32'd1);
    if (obs_q.size() == 2) check("t6_next_len", 32'(obs_q[1].len), 32'd3);

    // Random sequences under random gaps and backpressure
    for (int k = 0; k < 40; k++) begin
      q.delete();
      for (int i = 0, n = $urandom_range(1, 8); i < n; i++) begin
        q.push_back(8'($urandom));
      end
      send_seq(q, 1'b1);
    end
    drain();

    do_reset();
    @(negedge clk);
    check("final_rst_ovf", 32'(len_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_pair_feeder
